// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with per-frame digit latching and inter-digit blanking.
// Define SEG7_LZ_BLANK_EN to compile in leading-zero blanking of digit 3.
module seg7_scan #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 64,
   parameter int DP_DIGIT     = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   localparam int              PW        = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0]   PCNT_MAX  = PW'(REFRESH_DIV - 1);
   localparam logic [1:0]      DP_IDX    = 2'(DP_DIGIT);
   localparam logic [0:0]      ST_BLANK  = 1'b0;
   localparam logic [0:0]      ST_DRIVE  = 1'b1;

   logic [PW-1:0]   pcnt_q, pcnt_d;
   logic [1:0]      idx_q, idx_d;
   logic            started_q;
   logic [3:0][3:0] lat_q, lat_d;
   logic [3:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic            fs_q, fs_d;
   logic [0:0]      slotState;
   logic [3:0]      curDigit;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b0111111;
      endcase
   endfunction

   // The cycle right after reset only latches the frame; counting starts on the next edge.
   always_comb begin
      pcnt_d = pcnt_q;
      idx_d  = idx_q;
      lat_d  = lat_q;
      fs_d   = 1'b0;
      if (!started_q) begin
         fs_d = 1'b1;
      end else if (pcnt_q == PCNT_MAX) begin
         pcnt_d = '0;
         idx_d  = idx_q + 2'd1;
         if (idx_q == 2'd3) begin
            fs_d = 1'b1;
         end
      end else begin
         pcnt_d = pcnt_q + 1'b1;
      end
      if (fs_d) begin
         lat_d = {d3, d2, d1, d0};
      end
   end

   assign slotState = (started_q && (int'(pcnt_q) >= BLANK_CYCLES)) ? ST_DRIVE : ST_BLANK;
   assign curDigit  = lat_q[idx_q];

   always_comb begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (slotState == ST_DRIVE) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = decode(curDigit);
         dp_d  = (idx_q != DP_IDX);
`ifdef SEG7_LZ_BLANK_EN
         if ((idx_q == 2'd3) && (curDigit == 4'd0)) begin
            seg_d = 7'h7F;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcnt_q    <= '0;
         idx_q     <= 2'd0;
         started_q <= 1'b0;
         lat_q     <= '0;
         an_q      <= 4'b1111;
         seg_q     <= 7'h7F;
         dp_q      <= 1'b1;
         fs_q      <= 1'b0;
      end else begin
         pcnt_q    <= pcnt_d;
         idx_q     <= idx_d;
         started_q <= 1'b1;
         lat_q     <= lat_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         fs_q      <= fs_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: cycle-by-cycle comparison against a small scan/latch model.
// Expectations follow SEG7_LZ_BLANK_EN the same way the design does.
module tb_seg7_scan;

   localparam int RD = 4;
   localparam int BC = 1;
   localparam int DPD = 2;

   logic       clk;
   logic       reset_n;
   logic [3:0] d0, d1, d2, d3;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_start;

   int nChecks;
   int nPass;
   int k;
   logic [3:0] latModel [4];

   seg7_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .DP_DIGIT(DPD)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .d0(d0),
      .d1(d1),
      .d2(d2),
      .d3(d3),
      .an(an),
      .seg(seg),
      .dp(dp),
      .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] segOf(input logic [3:0] v);
      case (v)
         4'd0:    segOf = 7'h40;
         4'd1:    segOf = 7'h79;
         4'd2:    segOf = 7'h24;
         4'd3:    segOf = 7'h30;
         4'd4:    segOf = 7'h19;
         4'd5:    segOf = 7'h12;
         4'd6:    segOf = 7'h02;
         4'd7:    segOf = 7'h78;
         4'd8:    segOf = 7'h00;
         4'd9:    segOf = 7'h10;
         default: segOf = 7'h3F;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs === exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, k, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v3, input logic [3:0] v2,
                                input logic [3:0] v1, input logic [3:0] v0);
      d3 = v3;
      d2 = v2;
      d1 = v1;
      d0 = v0;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_an"}, 32'(an), 32'hF);
      checkOutput({tag, "_seg"}, 32'(seg), 32'h7F);
      checkOutput({tag, "_dp"}, 32'(dp), 32'h1);
      checkOutput({tag, "_fs"}, 32'(frame_start), 32'h0);
   endtask

   // Advance one clock, compare all outputs against the model, then update the model latch.
   task automatic stepAndCheck(output logic driving);
      int n, slot, pc;
      logic [3:0] expAn;
      logic [6:0] expSeg;
      logic       expDp, expFs;
      @(posedge clk);
      #1;
      k++;
      expAn  = 4'hF;
      expSeg = 7'h7F;
      expDp  = 1'b1;
      driving = 1'b0;
      if (k == 1) begin
         expFs = 1'b1;
      end else begin
         n     = k - 2;
         slot  = (n / RD) % 4;
         pc    = n % RD;
         expFs = ((n % (4 * RD)) == (4 * RD - 1));
         if (pc >= BC) begin
            driving = 1'b1;
            expAn   = 4'hF & ~(4'b0001 << slot);
            expSeg  = segOf(latModel[slot]);
            expDp   = (slot != DPD);
`ifdef SEG7_LZ_BLANK_EN
            if (slot == 3 && latModel[3] == 4'd0) expSeg = 7'h7F;
`endif
         end
      end
      checkOutput("an", 32'(an), 32'(expAn));
      checkOutput("seg", 32'(seg), 32'(expSeg));
      checkOutput("dp", 32'(dp), 32'(expDp));
      checkOutput("frame_start", 32'(frame_start), 32'(expFs));
      if (expFs) begin
         latModel[0] = d0;
         latModel[1] = d1;
         latModel[2] = d2;
         latModel[3] = d3;
      end
   endtask

   task automatic runCycles(input int cnt);
      logic drv;
      for (int i = 0; i < cnt; i++) stepAndCheck(drv);
   endtask

   initial begin
      logic drv;
      int   guard;
      nChecks = 0;
      nPass   = 0;
      k       = 0;
      for (int i = 0; i < 4; i++) latModel[i] = 4'd0;
      reset_n = 1'b0;
      applyStimulus(4'd1, 4'd2, 4'd3, 4'd4);

      repeat (2) @(posedge clk);
      #1;
      checkReset("reset_hold");
      #3;
      reset_n = 1'b1;

      runCycles(8);
      applyStimulus(4'd1, 4'd2, 4'd3, 4'd7);
      runCycles(32);

      applyStimulus(4'd1, 4'd2, 4'hC, 4'd7);
      runCycles(16);

      applyStimulus(4'd0, 4'd5, 4'd0, 4'd0);
      runCycles(24);

      guard = 0;
      drv = 1'b0;
      while (!drv && guard < 8) begin
         stepAndCheck(drv);
         guard++;
      end
      checkOutput("reach_drive", 32'(drv), 32'h1);
      #1;
      reset_n = 1'b0;
      #1;
      checkReset("async_reset");
      @(posedge clk);
      #1;
      checkReset("reset_held_edge");
      #3;
      reset_n = 1'b1;
      k = 0;
      applyStimulus(4'd9, 4'd8, 4'd6, 4'hF);
      runCycles(20);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
